// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface instr_fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            fault;
  logic [XLEN-1:0] fetch_cnt;

  // Fetch controller side
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output fault,
    output fetch_cnt
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  fault,
    input  fetch_cnt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC owner, 2-entry instruction buffer,
// decode handshake, redirect flush and misaligned-target halt.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_ctrl_if.master  bus
);
  localparam int unsigned XLEN = 32;

  // Elaboration guards on unsupported parameter values
  if (DEPTH != 2) begin : g_bad_depth
    $error("instr_fetch_ctrl: DEPTH must be 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instr_fetch_ctrl: RESET_PC must be word-aligned");
  end

  typedef enum logic {FETCH, HALT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  entry_t          e0_q, e0_d, e1_q, e1_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic            fault_q, fault_d;
  logic            pop, push;
  entry_t          e_new;

  assign e_new = {pc_q, bus.imem_rdata};

  // Next-state: slot 0 is always the head; empty slots are kept at zero
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    fault_d = fault_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH: begin
        pop  = v0_q & bus.if_ready;
        push = !bus.redirect_valid & (!v1_q | pop);
        if (pop) cnt_d = cnt_q + XLEN'(1);
        if (bus.redirect_valid) begin
          // Flush wins over a simultaneous pop
          e0_d = '0;
          e1_d = '0;
          v0_d = 1'b0;
          v1_d = 1'b0;
          if (bus.redirect_pc[1:0] == 2'b00) begin
            pc_d = bus.redirect_pc;
          end else begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end else begin
          if (pop) begin
            e0_d = e1_q;
            v0_d = v1_q;
            e1_d = '0;
            v1_d = 1'b0;
          end
          if (push) begin
            if (!v0_d) begin
              e0_d = e_new;
              v0_d = 1'b1;
            end else begin
              e1_d = e_new;
              v1_d = 1'b1;
            end
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      fault_q <= fault_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = v0_q;
  assign bus.if_instr  = e0_q.instr;
  assign bus.if_pc     = e0_q.pc;
  assign bus.fault     = fault_q;
  assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: expected PCs are queued with the
// stimulus and checked against every accepted decode handshake.
module tb_instr_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if ifa ();
  instr_fetch_ctrl_if ifb ();

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  // Instruction memory model: a bijective address hash
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0050_0093;
  endfunction

  assign ifa.imem_rdata = mem_word(ifa.imem_addr);
  assign ifb.imem_rdata = mem_word(ifb.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc = '0;
    ifa.if_ready = rdy;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: values at the falling edge are those the next rising edge uses
  always @(negedge clk) begin
    if (rst_n && ifa.if_valid && ifa.if_ready && !ifa.redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_handshake_pc", ifa.if_pc, 'x);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", ifa.if_pc, e);
        check("sb_instr", ifa.if_instr, mem_word(e));
      end
    end
  end

  logic [31:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    wrap_seq[3] = 32'h0000_0004;

    rst_n = 1'b0;
    ifa.if_ready = 1'b0;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc = '0;
    ifb.if_ready = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc = '0;
    tick();

    // Reset values
    check("rst_valid", 32'(ifa.if_valid), 32'd0);
    check("rst_instr", ifa.if_instr, 32'd0);
    check("rst_pc", ifa.if_pc, 32'd0);
    check("rst_fault", 32'(ifa.fault), 32'd0);
    check("rst_cnt", ifa.fetch_cnt, 32'd0);
    check("rst_addr", ifa.imem_addr, 32'd0);
    check("rst_addr_wrap", ifb.imem_addr, 32'hFFFF_FFF8);

    // Streaming with if_ready=1; wrap instance runs alongside
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    ifa.if_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_pc", ifb.if_pc, wrap_seq[i]);
      check("wrap_valid", 32'(ifb.if_valid), 32'd1);
      if (i == 0) begin
        check("first_valid", 32'(ifa.if_valid), 32'd1);
        check("first_pc", ifa.if_pc, 32'd0);
      end
    end
    tick();
    tick();
    check("stream_cnt", ifa.fetch_cnt, 32'd5);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);
    ifa.if_ready = 1'b0;

    // Back-pressure: buffer fills with 0,4 and the address sticks at 8
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("bp_addr", ifa.imem_addr, 32'h8);
    check("bp_valid", 32'(ifa.if_valid), 32'd1);
    check("bp_head", ifa.if_pc, 32'h0);
    check("bp_cnt", ifa.fetch_cnt, 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    ifa.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ifa.if_ready = 1'b0;
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bp_cnt_after", ifa.fetch_cnt, 32'd4);

    // Redirect to 0x40 while full (4,8) with if_ready=1
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("rd_pre_addr", ifa.imem_addr, 32'h8);
    exp_q.push_back(32'h0);
    ifa.if_ready = 1'b1;
    tick();
    check("rd_full_head", ifa.if_pc, 32'h4);
    check("rd_full_addr", ifa.imem_addr, 32'hC);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h40;
    tick();
    ifa.redirect_valid = 1'b0;
    check("rd_n1_valid", 32'(ifa.if_valid), 32'd0);
    check("rd_n1_addr", ifa.imem_addr, 32'h40);
    check("rd_n1_cnt", ifa.fetch_cnt, 32'd2);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    tick();
    check("rd_n2_valid", 32'(ifa.if_valid), 32'd1);
    check("rd_n2_pc", ifa.if_pc, 32'h40);
    tick();
    tick();
    ifa.if_ready = 1'b0;
    check("rd_q_empty", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect: fault, halt, later redirect ignored
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    tick();
    tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h42;
    tick();
    ifa.redirect_valid = 1'b0;
    check("mis_fault", 32'(ifa.fault), 32'd1);
    check("mis_valid", 32'(ifa.if_valid), 32'd0);
    check("mis_addr", ifa.imem_addr, 32'h8);
    check("mis_cnt", ifa.fetch_cnt, 32'd2);
    tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h80;
    tick();
    ifa.redirect_valid = 1'b0;
    tick();
    check("halt_addr", ifa.imem_addr, 32'h8);
    check("halt_fault", 32'(ifa.fault), 32'd1);
    check("halt_valid", 32'(ifa.if_valid), 32'd0);
    check("halt_cnt", ifa.fetch_cnt, 32'd2);
    check("halt_q_empty", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("halt_rst_fault", 32'(ifa.fault), 32'd0);
    check("halt_rst_addr", ifa.imem_addr, 32'd0);

    // Asynchronous reset between edges with the buffer full
    ifa.if_ready = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_full_valid", 32'(ifa.if_valid), 32'd1);
    check("mid_full_addr", ifa.imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ifa.if_valid), 32'd0);
    check("mid_rst_pc", ifa.if_pc, 32'd0);
    check("mid_rst_instr", ifa.if_instr, 32'd0);
    check("mid_rst_addr", ifa.imem_addr, 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
    ifa.if_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("restart_pc", ifa.if_pc, 32'd0);
    tick();
    tick();
    tick();
    ifa.if_ready = 1'b0;
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);
    check("restart_cnt", ifa.fetch_cnt, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
